// File: rtl/inverter_result_reader_if.sv
`default_nettype none
// ============================================================================
// Module      : inverter_result_reader_if
// Description : Bus between the inverter and the result reader, plus the
//               downstream show-ahead valid/ready read port.
// Revision    : 1.0 - initial release
// ============================================================================
interface inverter_result_reader_if #(
    parameter int W = 16
);
    logic         in_valid;
    logic [W-1:0] inv_do;
    logic [W-1:0] out_data;
    logic         out_valid;
    logic         out_ready;

    // Producer / reader side (drives samples and the ready strobe)
    modport master (
        output in_valid,
        output inv_do,
        output out_ready,
        input  out_data,
        input  out_valid
    );

    // Result-reader side
    modport slave (
        input  in_valid,
        input  inv_do,
        input  out_ready,
        output out_data,
        output out_valid
    );
endinterface
`default_nettype wire

// File: rtl/inverter_result_reader.sv
`default_nettype none
// ============================================================================
// Module      : inverter_result_reader
// Description : Tracks valid samples through the fixed-latency inverter,
//               captures matching results into a circular show-ahead buffer,
//               and drops/flags results that arrive while the buffer is full.
// Revision    : 1.0 - initial release
// ============================================================================
module inverter_result_reader #(
    parameter int LATENCY = 2,
    parameter int DEPTH   = 4,
    parameter int W       = 16
) (
    input  logic                     clk,
    input  logic                     rstn,
    inverter_result_reader_if.slave  bus,
    output logic                     overflow,
    input  logic                     clear_ovf,
    output logic [15:0]              result_count,
    output logic [7:0]               drop_count
);

    localparam int            c_AW   = $clog2(DEPTH);
    localparam logic [c_AW:0] c_FULL = DEPTH[c_AW:0];

    logic [LATENCY-1:0] r_tag;
    logic [W-1:0]       r_mem [DEPTH];
    logic [c_AW-1:0]    r_wr_ptr;
    logic [c_AW-1:0]    r_rd_ptr;
    logic [c_AW:0]      r_count;
    logic               r_overflow;
    logic [15:0]        r_result_count;
    logic [7:0]         r_drop_count;

    logic w_cap;
    logic w_pop;
    logic w_push;
    logic w_drop;

    // Tag chain marks which inverter output cycles carry a real result
    generate
        if (LATENCY == 1) begin : g_tag_single
            always_ff @(posedge clk) begin
                if (!rstn) r_tag <= '0;
                else       r_tag <= bus.in_valid;
            end
        end else begin : g_tag_chain
            always_ff @(posedge clk) begin
                if (!rstn) r_tag <= '0;
                else       r_tag <= {r_tag[LATENCY-2:0], bus.in_valid};
            end
        end
    endgenerate

    // A slot freed by a pop on the same edge may be reused by the capture
    always_comb begin
        w_cap  = r_tag[LATENCY-1];
        w_pop  = (r_count != '0) & bus.out_ready;
        w_push = w_cap & ((r_count < c_FULL) | w_pop);
        w_drop = w_cap & ~w_push;
    end

    assign bus.out_data  = r_mem[r_rd_ptr];
    assign bus.out_valid = (r_count != '0);
    assign overflow      = r_overflow;
    assign result_count  = r_result_count;
    assign drop_count    = r_drop_count;

    // Buffer storage; cleared on reset so out_data reads 0 afterwards
    always_ff @(posedge clk) begin
        if (!rstn) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else if (w_push) begin
            r_mem[r_wr_ptr] <= bus.inv_do;
        end
    end

    // Pointers and occupancy; pointers wrap naturally at the power-of-two depth
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Sticky overflow (set beats clear) and the result/drop statistics
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_overflow     <= 1'b0;
            r_result_count <= '0;
            r_drop_count   <= '0;
        end else begin
            if (w_drop)         r_overflow <= 1'b1;
            else if (clear_ovf) r_overflow <= 1'b0;
            if (w_push)         r_result_count <= r_result_count + 16'd1;
            if (w_drop && (r_drop_count != 8'hFF))
                r_drop_count <= r_drop_count + 8'd1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_inverter_result_reader.sv
`default_nettype none
// ============================================================================
// Module      : tb_inverter_result_reader
// Description : Self-checking bench: inverter model, queue-based reference
//               model, per-cycle compare, directed and randomized stimulus.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_inverter_result_reader;

    localparam int L = 2;
    localparam int D = 4;
    localparam int W = 16;

    typedef struct {
        int           due;
        logic [W-1:0] val;
    } pend_t;

    logic        clk;
    logic        rstn;
    logic        clear_ovf;
    logic        overflow;
    logic [15:0] result_count;
    logic [7:0]  drop_count;
    logic [W-1:0] di;

    inverter_result_reader_if #(.W(W)) bus ();

    inverter_result_reader #(.LATENCY(L), .DEPTH(D), .W(W)) u_dut (
        .clk          (clk),
        .rstn         (rstn),
        .bus          (bus.slave),
        .overflow     (overflow),
        .clear_ovf    (clear_ovf),
        .result_count (result_count),
        .drop_count   (drop_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Inverter stand-in: ~di after L edges, junk on cycles without a sample
    logic [W-1:0] r_dpipe [L];
    logic [L-1:0] r_vpipe;
    always @(posedge clk) begin
        r_dpipe[0] <= di;
        r_vpipe[0] <= bus.in_valid;
        for (int k = 1; k < L; k++) begin
            r_dpipe[k] <= r_dpipe[k-1];
            r_vpipe[k] <= r_vpipe[k-1];
        end
    end
    assign bus.inv_do = r_vpipe[L-1] ? ~r_dpipe[L-1] : 16'hDEAD;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: pending results keyed by due cycle, plain FIFO buffer
    pend_t        m_pend[$];
    logic [W-1:0] m_q[$];
    logic         m_ovf = 1'b0;
    int           m_rc = 0;
    int           m_dc = 0;
    int           m_cyc = 0;
    bit           m_started = 1'b0;

    always @(posedge clk) begin
        bit           pop;
        bit           cap;
        int           occ;
        logic [W-1:0] v;
        m_started = 1'b1;
        if (!rstn) begin
            m_pend.delete();
            m_q.delete();
            m_ovf = 1'b0;
            m_rc  = 0;
            m_dc  = 0;
        end else begin
            occ = m_q.size();
            pop = (occ != 0) && bus.out_ready;
            cap = (m_pend.size() != 0) && (m_pend[0].due == m_cyc);
            if (pop) void'(m_q.pop_front());
            if (cap) begin
                v = m_pend.pop_front().val;
                if (occ < D || pop) begin
                    m_q.push_back(v);
                    m_rc = (m_rc + 1) % 65536;
                end else begin
                    m_ovf = 1'b1;
                    if (m_dc < 255) m_dc++;
                end
            end
            if (!(cap && !(occ < D || pop)) && clear_ovf) m_ovf = 1'b0;
            if (bus.in_valid) m_pend.push_back('{m_cyc + L, ~di});
        end
        m_cyc++;
    end

    logic [W-1:0] popped[$];

    // Per-cycle comparison against the model, midway between edges
    always @(negedge clk) begin
        if (m_started) begin
            chk("out_valid", {31'd0, bus.out_valid}, {31'd0, m_q.size() != 0});
            if (m_q.size() != 0) chk("out_data", {16'd0, bus.out_data}, {16'd0, m_q[0]});
            chk("overflow", {31'd0, overflow}, {31'd0, m_ovf});
            chk("result_count", {16'd0, result_count}, m_rc);
            chk("drop_count", {24'd0, drop_count}, m_dc);
            chk("no_junk", {31'd0, bus.out_valid && bus.out_data == 16'hDEAD}, 32'd0);
            if (rstn && bus.out_valid && bus.out_ready) popped.push_back(bus.out_data);
        end
    end

    task automatic cyc(input logic v, input logic [W-1:0] d, input logic rdy);
        bus.in_valid  = v;
        di            = d;
        bus.out_ready = rdy;
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        cyc(1'b0, '0, 1'b0);
        rstn = 1'b1;
        popped.delete();
    endtask

    function automatic logic [W-1:0] rnd_di();
        logic [W-1:0] x;
        x = W'($urandom);
        if (x == 16'h2152) x = 16'h0001;
        return x;
    endfunction

    initial begin
        logic [W-1:0] t2 [4];
        rstn          = 1'b0;
        clear_ovf     = 1'b0;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b0;
        di            = 16'h1234;

        // 1: reset held with in_valid high, then capture exactly L edges later
        repeat (3) cyc(1'b1, 16'h1234, 1'b0);
        chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("rst_out_data", {16'd0, bus.out_data}, 32'd0);
        chk("rst_overflow", {31'd0, overflow}, 32'd0);
        chk("rst_result_count", {16'd0, result_count}, 32'd0);
        chk("rst_drop_count", {24'd0, drop_count}, 32'd0);
        rstn = 1'b1;
        cyc(1'b1, 16'h00FF, 1'b0);
        repeat (L - 1) cyc(1'b0, '0, 1'b0);
        chk("lat_not_yet", {31'd0, bus.out_valid}, 32'd0);
        cyc(1'b0, '0, 1'b0);
        chk("lat_exact", {31'd0, bus.out_valid}, 32'd1);
        chk("lat_data", {16'd0, bus.out_data}, 32'h0000FF00);

        // 2: in-order capture
        do_reset();
        t2 = '{16'd100, 16'd1000, 16'd10000, 16'd11111};
        for (int i = 0; i < 4; i++) cyc(1'b1, t2[i], 1'b1);
        repeat (L + 2) cyc(1'b0, '0, 1'b1);
        chk("t2_n", popped.size(), 32'd4);
        if (popped.size() == 4) begin
            chk("t2_d0", {16'd0, popped[0]}, 32'hFF9B);
            chk("t2_d1", {16'd0, popped[1]}, 32'hFC17);
            chk("t2_d2", {16'd0, popped[2]}, 32'hD8EF);
            chk("t2_d3", {16'd0, popped[3]}, 32'hD498);
        end
        chk("t2_rc", {16'd0, result_count}, 32'd4);
        chk("t2_dc", {24'd0, drop_count}, 32'd0);

        // 3: gaps; idle slots show junk on inv_do
        do_reset();
        cyc(1'b1, 16'h0A0A, 1'b0);
        cyc(1'b0, 16'h5555, 1'b0);
        cyc(1'b1, 16'h0303, 1'b0);
        cyc(1'b0, 16'h7777, 1'b0);
        repeat (L + 1) cyc(1'b0, '0, 1'b0);
        chk("t3_rc", {16'd0, result_count}, 32'd2);
        repeat (4) cyc(1'b0, '0, 1'b1);
        chk("t3_n", popped.size(), 32'd2);
        if (popped.size() == 2) begin
            chk("t3_d0", {16'd0, popped[0]}, 32'hF5F5);
            chk("t3_d1", {16'd0, popped[1]}, 32'hFCFC);
        end

        // 4: overflow with reader stalled, then clear
        do_reset();
        for (int i = 1; i <= 6; i++) cyc(1'b1, W'(i), 1'b0);
        repeat (L + 1) cyc(1'b0, '0, 1'b0);
        chk("t4_rc", {16'd0, result_count}, 32'd4);
        chk("t4_dc", {24'd0, drop_count}, 32'd2);
        chk("t4_ovf", {31'd0, overflow}, 32'd1);
        chk("t4_head", {16'd0, bus.out_data}, 32'hFFFE);
        clear_ovf = 1'b1;
        cyc(1'b0, '0, 1'b0);
        clear_ovf = 1'b0;
        chk("t4_clr", {31'd0, overflow}, 32'd0);

        // 5: full buffer drained while samples keep arriving
        popped.delete();
        for (int i = 0; i < 10; i++) cyc(1'b1, W'(16'h0100 + i), 1'b1);
        repeat (D + L + 2) cyc(1'b0, '0, 1'b1);
        chk("t5_dc", {24'd0, drop_count}, 32'd2);
        chk("t5_rc", {16'd0, result_count}, 32'd14);
        chk("t5_n", popped.size(), 32'd14);
        if (popped.size() == 14) begin
            chk("t5_d0", {16'd0, popped[0]}, 32'hFFFE);
            chk("t5_d3", {16'd0, popped[3]}, 32'hFFFB);
            chk("t5_d4", {16'd0, popped[4]}, 32'hFEFF);
            chk("t5_d13", {16'd0, popped[13]}, 32'hFEF6);
        end

        // 6: reset with results buffered and in flight
        do_reset();
        for (int i = 0; i < 5; i++) cyc(1'b1, W'(16'h0200 + i), 1'b0);
        chk("t6_pre_rc", {16'd0, result_count}, 32'd3);
        rstn = 1'b0;
        cyc(1'b0, '0, 1'b0);
        rstn = 1'b1;
        chk("t6_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("t6_rc", {16'd0, result_count}, 32'd0);
        popped.delete();
        repeat (L + 2) cyc(1'b0, '0, 1'b1);
        chk("t6_flight_lost", popped.size(), 32'd0);
        chk("t6_rc_after", {16'd0, result_count}, 32'd0);

        // Randomized traffic in phases of varying load and reader stall
        do_reset();
        for (int ph = 0; ph < 12; ph++) begin
            int pv;
            int pr;
            pv = $urandom_range(20, 100);
            pr = $urandom_range(0, 100);
            for (int c = 0; c < 250; c++) begin
                rstn      = ($urandom_range(0, 299) != 0);
                clear_ovf = ($urandom_range(0, 19) == 0);
                cyc($urandom_range(1, 100) <= pv, rnd_di(), $urandom_range(1, 100) <= pr);
            end
        end
        rstn      = 1'b1;
        clear_ovf = 1'b0;
        repeat (D + L + 2) cyc(1'b0, '0, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
